line_drawer_arbiter: RTL
========================

Name: line_drawer_arbiter

Overview:
- Shares one line_drawer instance between two requesters, e.g. the ball-trajectory sequencer and the villain-paddle path generator.
- Each requester presents a segment (x0,y0)->(x1,y1) with a level request. The arbiter grants round-robin, latches the endpoints, and holds ld_start until ld_done.
- After each segment it inserts a fixed gap so the drawer's done/registers clear, then acks the served requester.
- A watchdog aborts segments whose done never arrives.

Parameters:
- GAP_CYCLES, 2: idle cycles between segments (ld_start low); legal range 1..15.
- TIMEOUT, 1048576: maximum DRAW cycles before abort; legal range 2..2^21.
- CW, 11: signed coordinate width.

Ports:
- CLOCK_50  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-requester request level; bit i belongs to requester i.
- req_x0, req_y0, req_x1, req_y1  in  2 x CW signed  per-requester endpoints. Must be stable while req[i]=1 and gnt[i]=0.
- gnt  out  2  one-hot grant, or 0 when no requester is granted.
- ack  out  2  one-cycle pulse on bit i when requester i's segment completes.
- err  out  2  one-cycle pulse on bit i when requester i's segment times out.
- busy  out  1  high in DRAW and GAP.
- ld_start  out  1  drawer start.
- ld_x0, ld_y0, ld_x1, ld_y1  out  CW signed  latched endpoints.
- ld_done  in  1  drawer completion (level or pulse).

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, ack=0, err=0, busy=0, ld_start=0, ld_x0/ld_y0/ld_x1/ld_y1=0, state=IDLE, last=1 (so requester 0 wins first), wdog=0, gapcnt=0.
- rst has priority over every other event. Reset mid-DRAW drops ld_start the next cycle and produces no ack or err.

States:
- IDLE
  - If req==0: stay; gnt=0.
  - Else pick winner w:
    - only one bit set: w = that requester;
    - both set: w = ~last.
  - Next cycle: gnt=onehot(w); ld_* <= req_*[w]; ld_start=1; busy=1; last<=w; wdog<=0; go to DRAW.
- DRAW
  - ld_start held high; endpoints frozen; wdog increments every cycle.
  - If ld_done=1: next cycle ld_start=0, ack[w]=1 for one cycle, gnt=0; go to GAP.
  - Else if wdog==TIMEOUT-1: next cycle ld_start=0, err[w]=1 for one cycle, gnt=0; go to GAP.
  - If both conditions are true in the same cycle, done wins (ack, no err).
  - ld_done while not in DRAW is ignored.
- GAP
  - ld_start=0; busy=1; counts GAP_CYCLES cycles, then goes to IDLE with busy=0.
  - Requests are not sampled during GAP.

Timing and requester contract:
- Grant latency: 1 cycle from req rising in IDLE.
- Back-to-back minimum spacing: GAP_CYCLES+1 cycles from ack to the next ld_start.
- A requester must drop req in the cycle after its ack if it has no new segment. A req still high on return to IDLE is treated as a new request.
- Round-robin fairness: with both requesting continuously, grants strictly alternate 0,1,0,1.
- Endpoints are captured only at grant; changes to req_*[w] during DRAW have no effect.
- No arithmetic is performed on coordinates; they are passed through bit-exact. The wdog counter is 21 bits and does not wrap before TIMEOUT.

Decomposition:
- Package ld_arb_pkg:
  - state enum {IDLE, DRAW, GAP};
  - typedef logic signed [CW-1:0] coord_t;
  - struct seg_t {x0, y0, x1, y1}.
- One sub-module: rr_pick2 (combinational 2-way round-robin select: req, last -> winner, valid).
- Watchdog and gap counters stay inline in the top module.

Test Plan:
- Reset, then req=01 with seg (0,0)->(320,450):
  - gnt=01 and ld_start=1 one cycle later, ld_x1=320, ld_y1=450;
  - ld_done pulsed 10 cycles later -> ack=01 for exactly one cycle, then ld_start low for 2 cycles (GAP_CYCLES=2).
- Both req high from reset with seg0 (0,0)->(10,10) and seg1 (320,450)->(639,0):
  - grant order over 4 segments is 0,1,0,1;
  - ld_x0 equals 0,320,0,320 respectively.
- Change req_x1[0] to 100 during DRAW of requester 0 -> ld_x1 stays at its latched value until the segment's ack.
- TIMEOUT=8 and ld_done never asserted:
  - err=01 pulse exactly 8 cycles after ld_start rose, no ack;
  - arbiter returns to IDLE after the gap and serves the pending req[1] next.
- ld_done and wdog==TIMEOUT-1 in the same cycle -> ack pulse, err stays 0.
- Assert rst 3 cycles into DRAW:
  - next cycle gnt=0, ld_start=0, busy=0, no ack/err;
  - after release with both requesting, requester 0 is granted first.

Source files
------------

// File: rtl/ld_arb_pkg.sv
// Shared types for the two-requester line_drawer arbiter.
package ld_arb_pkg;

    localparam int CW_DEF = 11;

    typedef enum logic [1:0] {IDLE, DRAW, GAP} state_t;

    typedef logic signed [CW_DEF-1:0] coord_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
    } seg_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin select; a contested pick goes to the requester not served last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/line_drawer_arbiter.sv
// Shares one line_drawer between two segment requesters: round-robin grant,
// endpoint latch, start held until done, fixed inter-segment gap, watchdog abort.
module line_drawer_arbiter
    import ld_arb_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1048576,
    parameter int CW         = CW_DEF
) (
    input  logic                        CLOCK_50,
    input  logic                        rst,
    input  logic [1:0]                  req,
    input  logic signed [1:0][CW-1:0]   req_x0,
    input  logic signed [1:0][CW-1:0]   req_y0,
    input  logic signed [1:0][CW-1:0]   req_x1,
    input  logic signed [1:0][CW-1:0]   req_y1,
    output logic [1:0]                  gnt,
    output logic [1:0]                  ack,
    output logic [1:0]                  err,
    output logic                        busy,
    output logic                        ld_start,
    output logic signed [CW-1:0]        ld_x0,
    output logic signed [CW-1:0]        ld_y0,
    output logic signed [CW-1:0]        ld_x1,
    output logic signed [CW-1:0]        ld_y1,
    input  logic                        ld_done
);

    localparam logic [20:0] WDOG_LAST = 21'(TIMEOUT - 1);
    localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t              state, state_nxt;
    logic                last, last_nxt;
    logic [20:0]         wdog, wdog_nxt;
    logic [3:0]          gapcnt, gap_nxt;
    logic [1:0]          gnt_nxt, ack_nxt, err_nxt;
    logic                busy_nxt, start_nxt;
    logic signed [CW-1:0] x0_nxt, y0_nxt, x1_nxt, y1_nxt;
    logic                pick_w, pick_vld;

    rr_pick2 u_pick (
        .req    (req),
        .last   (last),
        .winner (pick_w),
        .valid  (pick_vld)
    );

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            wdog     <= '0;
            gapcnt   <= '0;
            gnt      <= '0;
            ack      <= '0;
            err      <= '0;
            busy     <= 1'b0;
            ld_start <= 1'b0;
            ld_x0    <= '0;
            ld_y0    <= '0;
            ld_x1    <= '0;
            ld_y1    <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            wdog     <= wdog_nxt;
            gapcnt   <= gap_nxt;
            gnt      <= gnt_nxt;
            ack      <= ack_nxt;
            err      <= err_nxt;
            busy     <= busy_nxt;
            ld_start <= start_nxt;
            ld_x0    <= x0_nxt;
            ld_y0    <= y0_nxt;
            ld_x1    <= x1_nxt;
            ld_y1    <= y1_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        wdog_nxt  = wdog;
        gap_nxt   = gapcnt;
        gnt_nxt   = gnt;
        ack_nxt   = '0;
        err_nxt   = '0;
        busy_nxt  = busy;
        start_nxt = ld_start;
        x0_nxt    = ld_x0;
        y0_nxt    = ld_y0;
        x1_nxt    = ld_x1;
        y1_nxt    = ld_y1;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (pick_vld) begin
                    state_nxt = DRAW;
                    gnt_nxt   = onehot2(pick_w);
                    x0_nxt    = req_x0[pick_w];
                    y0_nxt    = req_y0[pick_w];
                    x1_nxt    = req_x1[pick_w];
                    y1_nxt    = req_y1[pick_w];
                    start_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    last_nxt  = pick_w;
                    wdog_nxt  = '0;
                end
            end
            DRAW: begin
                // done is checked first so it wins over a simultaneous timeout
                if (ld_done) begin
                    state_nxt = GAP;
                    start_nxt = 1'b0;
                    ack_nxt   = onehot2(last);
                    gnt_nxt   = '0;
                    gap_nxt   = '0;
                end else if (wdog == WDOG_LAST) begin
                    state_nxt = GAP;
                    start_nxt = 1'b0;
                    err_nxt   = onehot2(last);
                    gnt_nxt   = '0;
                    gap_nxt   = '0;
                end else begin
                    wdog_nxt = wdog + 21'd1;
                end
            end
            GAP: begin
                if (gapcnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    gap_nxt = gapcnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
